alu_rs: RTL and testbench

- Reservation station in front of the integer ALU in the out-of-order core.
- Accepts dispatched ALU micro-ops whose operands may still be pending.
- Captures pending operands by snooping the common data bus (CDB).
- Issues one fully-ready micro-op per cycle: op1/op2/func go to the ALU, and the destination tag travels alongside for writeback.

---
 rtl/alu_rs_pkg.sv | 25 ++
 rtl/alu_rs_if.sv | 52 +++++
 rtl/alu_rs_entry.sv | 92 +++++++++
 rtl/alu_rs.sv | 94 +++++++++
 tb/tb_alu_rs.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/alu_rs_pkg.sv
// Shared definitions for the ALU reservation station: function codes,
// default geometry and operand-slot count.
package alu_rs_pkg;

  localparam int WIDTH_DEF = 32;
  localparam int DEPTH_DEF = 4;
  localparam int TAG_W_DEF = 4;
  localparam int FUNC_W    = 4;
  localparam int NUM_OPND  = 2;

  // Codes are carried through untouched; the ALU decides what undefined codes mean.
  typedef enum logic [FUNC_W-1:0] {
    ALU_OP_ADD  = 4'd0,
    ALU_OP_SUB  = 4'd1,
    ALU_OP_AND  = 4'd2,
    ALU_OP_OR   = 4'd3,
    ALU_OP_XOR  = 4'd4,
    ALU_OP_SLL  = 4'd5,
    ALU_OP_SRL  = 4'd6,
    ALU_OP_SRA  = 4'd7,
    ALU_OP_SLT  = 4'd8,
    ALU_OP_SLTU = 4'd9
  } alu_op_e;

endpackage

// File: rtl/alu_rs_if.sv
// Dispatch, CDB snoop and issue signals of the ALU reservation station.
// master = pipeline side, slave = the station.
interface alu_rs_if
  import alu_rs_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int TAG_W = TAG_W_DEF
);

  logic              flush;

  logic              disp_valid;
  logic              disp_ready;
  logic [FUNC_W-1:0] disp_func;
  logic [WIDTH-1:0]  disp_op1;
  logic              disp_op1_rdy;
  logic [TAG_W-1:0]  disp_op1_tag;
  logic [WIDTH-1:0]  disp_op2;
  logic              disp_op2_rdy;
  logic [TAG_W-1:0]  disp_op2_tag;
  logic [TAG_W-1:0]  disp_dest_tag;

  logic              cdb_valid;
  logic [TAG_W-1:0]  cdb_tag;
  logic [WIDTH-1:0]  cdb_data;

  logic              issue_valid;
  logic              issue_ready;
  logic [WIDTH-1:0]  alu_op1;
  logic [WIDTH-1:0]  alu_op2;
  logic [FUNC_W-1:0] alu_func;
  logic [TAG_W-1:0]  issue_dest_tag;

  modport master (
    output flush,
    output disp_valid, disp_func, disp_op1, disp_op1_rdy, disp_op1_tag,
    output disp_op2, disp_op2_rdy, disp_op2_tag, disp_dest_tag,
    output cdb_valid, cdb_tag, cdb_data,
    output issue_ready,
    input  disp_ready, issue_valid, alu_op1, alu_op2, alu_func, issue_dest_tag
  );

  modport slave (
    input  flush,
    input  disp_valid, disp_func, disp_op1, disp_op1_rdy, disp_op1_tag,
    input  disp_op2, disp_op2_rdy, disp_op2_tag, disp_dest_tag,
    input  cdb_valid, cdb_tag, cdb_data,
    input  issue_ready,
    output disp_ready, issue_valid, alu_op1, alu_op2, alu_func, issue_dest_tag
  );

endinterface

// File: rtl/alu_rs_entry.sv
// One reservation-station slot: holds a micro-op and snoops the CDB to
// capture operands that were still pending at dispatch.
module alu_rs_entry
  import alu_rs_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int TAG_W = TAG_W_DEF
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             flush,
  input  logic                             load,
  input  logic                             clear,
  input  logic [FUNC_W-1:0]                load_func,
  input  logic [TAG_W-1:0]                 load_dest_tag,
  input  logic [NUM_OPND-1:0]              load_rdy,
  input  logic [NUM_OPND-1:0][TAG_W-1:0]   load_tag,
  input  logic [NUM_OPND-1:0][WIDTH-1:0]   load_val,
  input  logic                             cdb_valid,
  input  logic [TAG_W-1:0]                 cdb_tag,
  input  logic [WIDTH-1:0]                 cdb_data,
  output logic                             valid,
  output logic                             ready,
  output logic [FUNC_W-1:0]                func,
  output logic [TAG_W-1:0]                 dest_tag,
  output logic [NUM_OPND-1:0][WIDTH-1:0]   op_val
);

  logic              valid_reg;
  logic [FUNC_W-1:0] func_reg;
  logic [TAG_W-1:0]  dest_reg;
  logic [NUM_OPND-1:0] rdy_vec;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_reg <= 1'b0;
      func_reg  <= '0;
      dest_reg  <= '0;
    end else if (flush) begin
      valid_reg <= 1'b0;
    end else if (load) begin
      valid_reg <= 1'b1;
      func_reg  <= load_func;
      dest_reg  <= load_dest_tag;
    end else if (clear) begin
      valid_reg <= 1'b0;
    end
  end

  genvar gi;
  for (gi = 0; gi < NUM_OPND; gi++) begin : g_opnd
    logic             rdy_reg;
    logic [TAG_W-1:0] tag_reg;
    logic [WIDTH-1:0] val_reg;
    logic             hit;

    // During a load the incoming tag is compared so a same-cycle broadcast is not missed.
    assign hit = cdb_valid && (cdb_tag == (load ? load_tag[gi] : tag_reg));

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rdy_reg <= 1'b0;
        tag_reg <= '0;
        val_reg <= '0;
      end else if (load) begin
        tag_reg <= load_tag[gi];
        if (load_rdy[gi]) begin
          rdy_reg <= 1'b1;
          val_reg <= load_val[gi];
        end else if (hit) begin
          rdy_reg <= 1'b1;
          val_reg <= cdb_data;
        end else begin
          rdy_reg <= 1'b0;
          val_reg <= load_val[gi];
        end
      end else if (valid_reg && !rdy_reg && hit) begin
        rdy_reg <= 1'b1;
        val_reg <= cdb_data;
      end
    end

    assign rdy_vec[gi] = rdy_reg;
    assign op_val[gi]  = val_reg;
  end

  assign valid    = valid_reg;
  assign ready    = valid_reg && (&rdy_vec);
  assign func     = func_reg;
  assign dest_tag = dest_reg;

endmodule

// File: rtl/alu_rs.sv
// ALU reservation station: dispatches into the lowest free slot and issues
// the lowest-index slot whose operands are both present.
module alu_rs
  import alu_rs_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int TAG_W = TAG_W_DEF
) (
  input  logic   clk,
  input  logic   rst_n,
  alu_rs_if.slave bus
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DEPTH-1:0]                    ent_valid;
  logic [DEPTH-1:0]                    ent_ready;
  logic [DEPTH-1:0]                    load_vec;
  logic [DEPTH-1:0]                    clear_vec;
  logic [FUNC_W-1:0]                   ent_func [DEPTH];
  logic [TAG_W-1:0]                    ent_dest [DEPTH];
  logic [NUM_OPND-1:0][WIDTH-1:0]      ent_opv  [DEPTH];

  logic             free_found;
  logic [IDX_W-1:0] free_idx;
  logic             sel_found;
  logic [IDX_W-1:0] sel_idx;
  logic             disp_fire;
  logic             issue_fire;

  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!ent_valid[i]) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
    end
  end

  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (ent_ready[i]) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'(i);
      end
    end
  end

  // Free slot comes from registered state, so an issuing slot is only reused next cycle.
  assign disp_fire  = bus.disp_valid && free_found && !bus.flush;
  assign issue_fire = sel_found && bus.issue_ready && !bus.flush;
  assign load_vec   = disp_fire  ? (DEPTH'(1) << free_idx) : '0;
  assign clear_vec  = issue_fire ? (DEPTH'(1) << sel_idx)  : '0;

  genvar gi;
  for (gi = 0; gi < DEPTH; gi++) begin : g_entry
    alu_rs_entry #(
      .WIDTH (WIDTH),
      .TAG_W (TAG_W)
    ) u_entry (
      .clk           (clk),
      .rst_n         (rst_n),
      .flush         (bus.flush),
      .load          (load_vec[gi]),
      .clear         (clear_vec[gi]),
      .load_func     (bus.disp_func),
      .load_dest_tag (bus.disp_dest_tag),
      .load_rdy      ({bus.disp_op2_rdy, bus.disp_op1_rdy}),
      .load_tag      ({bus.disp_op2_tag, bus.disp_op1_tag}),
      .load_val      ({bus.disp_op2, bus.disp_op1}),
      .cdb_valid     (bus.cdb_valid),
      .cdb_tag       (bus.cdb_tag),
      .cdb_data      (bus.cdb_data),
      .valid         (ent_valid[gi]),
      .ready         (ent_ready[gi]),
      .func          (ent_func[gi]),
      .dest_tag      (ent_dest[gi]),
      .op_val        (ent_opv[gi])
    );
  end

  assign bus.disp_ready     = free_found;
  assign bus.issue_valid    = sel_found;
  assign bus.alu_op1        = sel_found ? ent_opv[sel_idx][0] : '0;
  assign bus.alu_op2        = sel_found ? ent_opv[sel_idx][1] : '0;
  assign bus.alu_func       = sel_found ? ent_func[sel_idx]   : '0;
  assign bus.issue_dest_tag = sel_found ? ent_dest[sel_idx]   : '0;

endmodule

// File: tb/tb_alu_rs.sv
// Directed test of the ALU reservation station: dispatch, CDB bypass and
// wakeup, full-station back-pressure, select priority, flush and reset.
module tb_alu_rs;
  import alu_rs_pkg::*;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  alu_rs_if #(.WIDTH(32), .TAG_W(4)) bus ();

  alu_rs #(.WIDTH(32), .DEPTH(4), .TAG_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_issue(input string tag, input logic v, input logic [31:0] o1,
                           input logic [31:0] o2, input logic [3:0] f, input logic [3:0] d);
    chk({tag, ".valid"}, 32'(bus.issue_valid), 32'(v));
    chk({tag, ".op1"},   bus.alu_op1, o1);
    chk({tag, ".op2"},   bus.alu_op2, o2);
    chk({tag, ".func"},  32'(bus.alu_func), 32'(f));
    chk({tag, ".dest"},  32'(bus.issue_dest_tag), 32'(d));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.disp_valid = 1'b0;
    bus.cdb_valid  = 1'b0;
    bus.flush      = 1'b0;
  endtask

  task automatic set_disp(input logic [3:0] f, input logic [31:0] o1, input logic r1,
                          input logic [3:0] t1, input logic [31:0] o2, input logic r2,
                          input logic [3:0] t2, input logic [3:0] d);
    bus.disp_valid    = 1'b1;
    bus.disp_func     = f;
    bus.disp_op1      = o1;
    bus.disp_op1_rdy  = r1;
    bus.disp_op1_tag  = t1;
    bus.disp_op2      = o2;
    bus.disp_op2_rdy  = r2;
    bus.disp_op2_tag  = t2;
    bus.disp_dest_tag = d;
    $display("disp func=%0d op1=%0h/%0b/%0d op2=%0h/%0b/%0d dest=%0d", f, o1, r1, t1, o2, r2, t2, d);
  endtask

  task automatic set_cdb(input logic [3:0] t, input logic [31:0] data);
    bus.cdb_valid = 1'b1;
    bus.cdb_tag   = t;
    bus.cdb_data  = data;
    $display("cdb tag=%0d data=%0h", t, data);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    idle();
    bus.issue_ready = 1'b0;
    set_disp(ALU_OP_ADD, 0, 1'b0, 0, 0, 1'b0, 0, 0);
    bus.disp_valid = 1'b0;
    set_cdb(0, 0);
    bus.cdb_valid = 1'b0;

    // Reset state
    #12;
    chk_issue("reset", 1'b0, 0, 0, 4'd0, 4'd0);
    chk("reset.disp_ready", 32'(bus.disp_ready), 32'd1);
    rst_n = 1'b1;
    tick();

    // Simple ready ADD
    set_disp(ALU_OP_ADD, 32'd5, 1'b1, 4'd0, 32'd7, 1'b1, 4'd0, 4'd3);
    bus.issue_ready = 1'b1;
    tick();
    idle();
    chk_issue("add", 1'b1, 32'd5, 32'd7, ALU_OP_ADD, 4'd3);
    tick();
    chk_issue("add_freed", 1'b0, 0, 0, 4'd0, 4'd0);
    chk("add_freed.disp_ready", 32'(bus.disp_ready), 32'd1);

    // SUB with op2 woken by CDB two cycles later
    set_disp(ALU_OP_SUB, 32'd10, 1'b1, 4'd0, 32'd0, 1'b0, 4'd6, 4'd5);
    tick();
    idle();
    chk("sub_wait1.valid", 32'(bus.issue_valid), 32'd0);
    tick();
    chk("sub_wait2.valid", 32'(bus.issue_valid), 32'd0);
    set_cdb(4'd6, 32'd4);
    tick();
    idle();
    chk_issue("sub_woken", 1'b1, 32'd10, 32'd4, ALU_OP_SUB, 4'd5);
    tick();
    chk("sub_done.valid", 32'(bus.issue_valid), 32'd0);

    // Dispatch-cycle CDB bypass on op1
    set_disp(ALU_OP_AND, 32'd0, 1'b0, 4'd2, 32'd9, 1'b1, 4'd0, 4'd7);
    set_cdb(4'd2, 32'hFFFF_FFFF);
    tick();
    idle();
    chk_issue("bypass", 1'b1, 32'hFFFF_FFFF, 32'd9, ALU_OP_AND, 4'd7);
    tick();
    chk("bypass_done.valid", 32'(bus.issue_valid), 32'd0);

    // Fill all four slots while the ALU stalls
    bus.issue_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      set_disp(ALU_OP_OR, 32'(i + 1), 1'b1, 4'd0, 32'(16 * i), 1'b1, 4'd0, 4'(8 + i));
      tick();
    end
    idle();
    chk("full.disp_ready", 32'(bus.disp_ready), 32'd0);
    chk_issue("full.head", 1'b1, 32'd1, 32'd0, ALU_OP_OR, 4'd8);
    set_disp(ALU_OP_XOR, 32'd99, 1'b1, 4'd0, 32'd99, 1'b1, 4'd0, 4'd12);
    tick();
    idle();
    chk("full_reject.disp_ready", 32'(bus.disp_ready), 32'd0);
    chk("full_reject.dest", 32'(bus.issue_dest_tag), 32'd8);
    bus.issue_ready = 1'b1;
    tick();
    bus.issue_ready = 1'b0;
    chk("one_issue.disp_ready", 32'(bus.disp_ready), 32'd1);
    chk_issue("one_issue.next", 1'b1, 32'd2, 32'd16, ALU_OP_OR, 4'd9);
    tick();
    chk_issue("stall_hold", 1'b1, 32'd2, 32'd16, ALU_OP_OR, 4'd9);
    bus.issue_ready = 1'b1;
    tick();
    chk("drain1.dest", 32'(bus.issue_dest_tag), 32'd10);
    tick();
    chk("drain2.dest", 32'(bus.issue_dest_tag), 32'd11);
    tick();
    chk("drain_empty.valid", 32'(bus.issue_valid), 32'd0);

    // Select priority: slot0 pending, slot1 ready, slot2 pending, slot3 ready
    bus.issue_ready = 1'b0;
    set_disp(ALU_OP_XOR, 32'd0, 1'b0, 4'd1, 32'd1, 1'b1, 4'd0, 4'd1);
    tick();
    set_disp(ALU_OP_SLL, 32'd2, 1'b1, 4'd0, 32'd3, 1'b1, 4'd0, 4'd2);
    tick();
    set_disp(ALU_OP_SRL, 32'd0, 1'b0, 4'd13, 32'd5, 1'b1, 4'd0, 4'd3);
    tick();
    set_disp(ALU_OP_SRA, 32'd6, 1'b1, 4'd0, 32'd7, 1'b1, 4'd0, 4'd4);
    tick();
    idle();
    chk_issue("prio.first", 1'b1, 32'd2, 32'd3, ALU_OP_SLL, 4'd2);
    bus.issue_ready = 1'b1;
    tick();
    bus.issue_ready = 1'b0;
    chk_issue("prio.second", 1'b1, 32'd6, 32'd7, ALU_OP_SRA, 4'd4);
    set_cdb(4'd1, 32'h55);
    tick();
    idle();
    chk_issue("prio.wake0", 1'b1, 32'h55, 32'd1, ALU_OP_XOR, 4'd1);
    bus.issue_ready = 1'b1;
    tick();
    chk("prio.after0.dest", 32'(bus.issue_dest_tag), 32'd4);
    tick();
    chk("prio.pending_only.valid", 32'(bus.issue_valid), 32'd0);

    // Flush with three valid slots (slot2 still pending on tag 13) and a concurrent dispatch
    bus.issue_ready = 1'b0;
    set_disp(ALU_OP_ADD, 32'd0, 1'b0, 4'd14, 32'd1, 1'b1, 4'd0, 4'd5);
    tick();
    set_disp(ALU_OP_SUB, 32'd8, 1'b1, 4'd0, 32'd9, 1'b1, 4'd0, 4'd6);
    tick();
    idle();
    chk("preflush.dest", 32'(bus.issue_dest_tag), 32'd6);
    set_disp(ALU_OP_OR, 32'd1, 1'b1, 4'd0, 32'd1, 1'b1, 4'd0, 4'd7);
    bus.flush = 1'b1;
    bus.issue_ready = 1'b1;
    tick();
    idle();
    chk_issue("flush", 1'b0, 0, 0, 4'd0, 4'd0);
    chk("flush.disp_ready", 32'(bus.disp_ready), 32'd1);
    set_cdb(4'd13, 32'h13);
    tick();
    set_cdb(4'd14, 32'h14);
    tick();
    idle();
    chk("flush_stale13.valid", 32'(bus.issue_valid), 32'd0);
    tick();
    chk("flush_stale14.valid", 32'(bus.issue_valid), 32'd0);

    // Asynchronous reset with a stalled ready entry
    bus.issue_ready = 1'b0;
    set_disp(ALU_OP_SLT, 32'd3, 1'b1, 4'd0, 32'd4, 1'b1, 4'd0, 4'd9);
    tick();
    idle();
    chk("prereset.dest", 32'(bus.issue_dest_tag), 32'd9);
    #1;
    rst_n = 1'b0;
    #1;
    chk_issue("async_reset", 1'b0, 0, 0, 4'd0, 4'd0);
    rst_n = 1'b1;
    tick();
    chk("post_reset.valid", 32'(bus.issue_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
